seven_seg_capture: RTL and testbench

Receive-side monitor for the multiplexed 7-segment display bus in the parking controller. It samples the scanned segment/anode lines and decodes each segment pattern back to a digit code. It reassembles the four-digit frame and publishes it once the same frame has been seen on consecutive scans. It sits beside the display driver as a built-in self-test / readback path, so firmware and testbenches can confirm what is actually shown on the occupancy display.

---
 rtl/seven_seg_capture_if.sv | 27 ++
 rtl/seven_seg_capture.sv | 178 +++++++++++++++++
 tb/tb_seven_seg_capture.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_if.sv
// Scanned 7-segment bus plus the capture results, shared between the
// display side (master drives segments/anodes) and the capture monitor.
interface seven_seg_capture_if;
  logic [7:0] seg_in;
  logic [4:0] anode_in;
  logic [3:0] digit_0;
  logic [3:0] digit_1;
  logic [3:0] digit_2;
  logic [3:0] digit_3;
  logic       digits_valid;
  logic       frame_strobe;
  logic       seg_err;
  logic       anode_err;
  logic       seq_err;

  modport master (
    output seg_in, anode_in,
    input  digit_0, digit_1, digit_2, digit_3,
    input  digits_valid, frame_strobe, seg_err, anode_err, seq_err
  );

  modport slave (
    input  seg_in, anode_in,
    output digit_0, digit_1, digit_2, digit_3,
    output digits_valid, frame_strobe, seg_err, anode_err, seq_err
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Readback monitor for the multiplexed 7-segment display: registers the
// scanned lines, decodes each lit digit, reassembles the 4-digit frame and
// publishes it once STABLE_FRAMES identical frames arrive back to back.
module seven_seg_capture #(
  parameter logic [3:0] STABLE_FRAMES = 4'd2
) (
  input  logic              clk,
  input  logic              reset,
  seven_seg_capture_if.slave bus
);

  localparam logic [0:0] SYNC    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  // Segment pattern to {known, code}; unknown patterns map to code E.
  function automatic logic [4:0] seg_decode(input logic [7:0] pat);
    logic [4:0] r;
    case (pat)
      8'h3F:   r = {1'b1, 4'h0};
      8'h06:   r = {1'b1, 4'h1};
      8'h5B:   r = {1'b1, 4'h2};
      8'h4F:   r = {1'b1, 4'h3};
      8'h66:   r = {1'b1, 4'h4};
      8'h40:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'hE};
    endcase
    return r;
  endfunction

  logic [7:0]      seg_q, seg_d;
  logic [4:0]      anode_q, anode_d;
  logic [0:0]      state_q, state_d;
  logic [1:0]      last_slot_q, last_slot_d;
  logic [3:0][3:0] slot_buf_q, slot_buf_d;
  logic [3:0]      match_cnt_q, match_cnt_d;
  logic [3:0][3:0] prev_frame_q, prev_frame_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic            digits_valid_q, digits_valid_d;
  logic            frame_strobe_q, frame_strobe_d;
  logic            seg_err_q, seg_err_d;
  logic            anode_err_q, anode_err_d;
  logic            seq_err_q, seq_err_d;

  logic            slot_vld_s;
  logic [1:0]      slot_s;
  logic [4:0]      dec_s;
  logic            frame_done_s;

  // Slot/segment decode, scan-order FSM and frame stability tracking.
  always_comb begin
    seg_d          = bus.seg_in;
    anode_d        = bus.anode_in;
    state_d        = state_q;
    last_slot_d    = last_slot_q;
    slot_buf_d     = slot_buf_q;
    match_cnt_d    = match_cnt_q;
    prev_frame_d   = prev_frame_q;
    digits_d       = digits_q;
    digits_valid_d = digits_valid_q;
    frame_strobe_d = 1'b0;
    seg_err_d      = 1'b0;
    anode_err_d    = 1'b0;
    seq_err_d      = 1'b0;
    slot_vld_s     = 1'b0;
    slot_s         = 2'd0;
    frame_done_s   = 1'b0;
    dec_s          = seg_decode(seg_q);

    case (anode_q)
      5'b00001: begin slot_vld_s = 1'b1; slot_s = 2'd0; end
      5'b00010: begin slot_vld_s = 1'b1; slot_s = 2'd1; end
      5'b00100: begin slot_vld_s = 1'b1; slot_s = 2'd2; end
      5'b01000: begin slot_vld_s = 1'b1; slot_s = 2'd3; end
      5'b00000: begin slot_vld_s = 1'b0; end
      default:  begin anode_err_d = 1'b1; end
    endcase

    if (slot_vld_s) begin
      seg_err_d = ~dec_s[4];
      if (state_q == SYNC) begin
        // Only the leftmost slot can start a frame.
        if (slot_s == 2'd0) begin
          slot_buf_d[2'd0] = dec_s[3:0];
          last_slot_d      = 2'd0;
          state_d          = COLLECT;
        end else begin
          state_d = SYNC;
        end
      end else if (slot_s == last_slot_q) begin
        slot_buf_d[slot_s] = dec_s[3:0];
      end else if (slot_s == last_slot_q + 2'd1) begin
        slot_buf_d[slot_s] = dec_s[3:0];
        last_slot_d        = slot_s;
        if (slot_s == 2'd3) begin
          frame_done_s = 1'b1;
          state_d      = SYNC;
        end else begin
          state_d = COLLECT;
        end
      end else begin
        // Order broken: drop the partial frame; slot 0 restarts immediately.
        seq_err_d   = 1'b1;
        match_cnt_d = 4'd0;
        if (slot_s == 2'd0) begin
          slot_buf_d[2'd0] = dec_s[3:0];
          last_slot_d      = 2'd0;
          state_d          = COLLECT;
        end else begin
          state_d = SYNC;
        end
      end
    end else begin
      seg_err_d = 1'b0;
    end

    if (frame_done_s) begin
      if (slot_buf_d == prev_frame_q) begin
        match_cnt_d = (match_cnt_q == 4'd15) ? 4'd15 : match_cnt_q + 4'd1;
      end else begin
        match_cnt_d = 4'd1;
      end
      prev_frame_d = slot_buf_d;
      if (match_cnt_d >= STABLE_FRAMES) begin
        digits_d       = slot_buf_d;
        digits_valid_d = 1'b1;
        frame_strobe_d = 1'b1;
      end else begin
        digits_d = digits_q;
      end
    end else begin
      prev_frame_d = prev_frame_q;
    end
  end

  // Input capture stage and all capture state, cleared by async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q          <= 8'h00;
      anode_q        <= 5'b00000;
      state_q        <= SYNC;
      last_slot_q    <= 2'd0;
      slot_buf_q     <= 16'hFFFF;
      match_cnt_q    <= 4'd0;
      prev_frame_q   <= 16'hFFFF;
      digits_q       <= 16'hFFFF;
      digits_valid_q <= 1'b0;
      frame_strobe_q <= 1'b0;
      seg_err_q      <= 1'b0;
      anode_err_q    <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      seg_q          <= seg_d;
      anode_q        <= anode_d;
      state_q        <= state_d;
      last_slot_q    <= last_slot_d;
      slot_buf_q     <= slot_buf_d;
      match_cnt_q    <= match_cnt_d;
      prev_frame_q   <= prev_frame_d;
      digits_q       <= digits_d;
      digits_valid_q <= digits_valid_d;
      frame_strobe_q <= frame_strobe_d;
      seg_err_q      <= seg_err_d;
      anode_err_q    <= anode_err_d;
      seq_err_q      <= seq_err_d;
    end
  end

  assign bus.digit_0      = digits_q[0];
  assign bus.digit_1      = digits_q[1];
  assign bus.digit_2      = digits_q[2];
  assign bus.digit_3      = digits_q[3];
  assign bus.digits_valid = digits_valid_q;
  assign bus.frame_strobe = frame_strobe_q;
  assign bus.seg_err      = seg_err_q;
  assign bus.anode_err    = anode_err_q;
  assign bus.seq_err      = seq_err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus randomized scans,
// every cycle compared against a frame-level reference model.
module tb_seven_seg_capture;
  localparam int N = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seven_seg_capture_if bus();

  seven_seg_capture #(.STABLE_FRAMES(4'(N))) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int strobes_seen = 0;
  int seg_seen = 0;
  int an_seen  = 0;
  int seq_seen = 0;

  // Reference model: expected slot (-1 = waiting for slot 0), frame buffer,
  // consecutive-match count and last published digits.
  int         m_last;
  logic [3:0] m_buf [4];
  int         m_cnt;
  logic [15:0] m_prev;
  logic [15:0] m_dig;
  logic       m_valid, e_strobe, e_seg, e_an, e_seq;
  logic [7:0] p_seg;
  logic [4:0] p_an;

  function automatic logic [7:0] enc(input logic [3:0] c);
    case (c)
      4'h0: return 8'h3F;
      4'h1: return 8'h06;
      4'h2: return 8'h5B;
      4'h3: return 8'h4F;
      4'h4: return 8'h66;
      4'hF: return 8'h40;
      default: return 8'h7F;
    endcase
  endfunction

  function automatic logic [3:0] dec(input logic [7:0] p);
    case (p)
      8'h3F: return 4'h0;
      8'h06: return 4'h1;
      8'h5B: return 4'h2;
      8'h4F: return 4'h3;
      8'h66: return 4'h4;
      8'h40: return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = -1;
    for (int i = 0; i < 4; i++) m_buf[i] = 4'hF;
    m_cnt = 0; m_prev = 16'hFFFF; m_dig = 16'hFFFF; m_valid = 1'b0;
    e_strobe = 1'b0; e_seg = 1'b0; e_an = 1'b0; e_seq = 1'b0;
    p_seg = 8'h00; p_an = 5'b00000;
  endtask

  task automatic model_step(input logic [7:0] seg, input logic [4:0] an);
    int s;
    logic [3:0] code;
    logic [15:0] frame;
    e_strobe = 1'b0; e_seg = 1'b0; e_an = 1'b0; e_seq = 1'b0;
    case (an)
      5'b00001: s = 0;
      5'b00010: s = 1;
      5'b00100: s = 2;
      5'b01000: s = 3;
      5'b00000: s = -1;
      default:  s = -2;
    endcase
    if (s == -2) e_an = 1'b1;
    else if (s >= 0) begin
      code  = dec(seg);
      e_seg = (code == 4'hE);
      if (m_last < 0) begin
        if (s == 0) begin m_buf[0] = code; m_last = 0; end
      end else if (s == m_last) begin
        m_buf[s] = code;
      end else if (s == m_last + 1) begin
        m_buf[s] = code;
        m_last = s;
        if (s == 3) begin
          m_last = -1;
          frame = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          if (frame == m_prev) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
          else m_cnt = 1;
          m_prev = frame;
          if (m_cnt >= N) begin m_dig = frame; m_valid = 1'b1; e_strobe = 1'b1; end
        end
      end else begin
        e_seq = 1'b1; m_cnt = 0; m_last = -1;
        if (s == 0) begin m_buf[0] = code; m_last = 0; end
      end
    end
  endtask

  task automatic check_outputs(input string sfx);
    check({"digits", sfx}, {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, m_dig);
    check({"digits_valid", sfx}, 16'(bus.digits_valid), 16'(m_valid));
    check({"frame_strobe", sfx}, 16'(bus.frame_strobe), 16'(e_strobe));
    check({"seg_err", sfx}, 16'(bus.seg_err), 16'(e_seg));
    check({"anode_err", sfx}, 16'(bus.anode_err), 16'(e_an));
    check({"seq_err", sfx}, 16'(bus.seq_err), 16'(e_seq));
  endtask

  // One clock: present a sample, then check outputs produced by the previous one.
  task automatic cyc(input logic [7:0] seg, input logic [4:0] an);
    bus.seg_in = seg;
    bus.anode_in = an;
    @(posedge clk);
    #1;
    model_step(p_seg, p_an);
    p_seg = seg;
    p_an = an;
    if (bus.frame_strobe) strobes_seen++;
    if (bus.seg_err) seg_seen++;
    if (bus.anode_err) an_seen++;
    if (bus.seq_err) seq_seen++;
    check_outputs("");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, 5'b00000);
  endtask

  task automatic scan(input logic [3:0] c0, input logic [3:0] c1,
                      input logic [3:0] c2, input logic [3:0] c3);
    cyc(enc(c0), 5'b00001);
    cyc(enc(c1), 5'b00010);
    cyc(enc(c2), 5'b00100);
    cyc(enc(c3), 5'b01000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.seg_in = 8'h00;
    bus.anode_in = 5'b00000;
    #1;
    model_reset();
    check_outputs("_in_reset");
    check("reset_digits", {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 16'hFFFF);
    check("reset_valid", 16'(bus.digits_valid), 16'h0000);
    @(posedge clk);
    #1;
    check_outputs("_in_reset");
    reset = 1'b0;
  endtask

  int base;
  int sbase;
  int abase;
  int qbase;
  logic [15:0] pool [3];
  logic [15:0] f;
  int r;

  initial begin
    pool[0] = 16'h3210;
    pool[1] = 16'hF4F1;
    pool[2] = 16'h1E40;
    bus.seg_in = 8'h00;
    bus.anode_in = 5'b00000;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Two identical scans publish 1,2,3,4 two cycles after the last sample.
    scan(4'h1, 4'h2, 4'h3, 4'h4);
    scan(4'h1, 4'h2, 4'h3, 4'h4);
    check("s1_no_strobe_yet", 16'(strobes_seen), 16'd0);
    idle(1);
    check("s1_strobes", 16'(strobes_seen), 16'd1);
    check("s1_digits", {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 16'h4321);
    check("s1_valid", 16'(bus.digits_valid), 16'd1);
    idle(2);

    // Alternating frames never stabilise; a repeat then publishes.
    do_reset();
    base = strobes_seen;
    scan(4'h0, 4'h1, 4'h2, 4'h3);
    scan(4'h0, 4'h1, 4'h2, 4'h4);
    scan(4'h0, 4'h1, 4'h2, 4'h3);
    scan(4'h0, 4'h1, 4'h2, 4'h4);
    idle(1);
    check("s2_no_strobe", 16'(strobes_seen - base), 16'd0);
    check("s2_digits_f", {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 16'hFFFF);
    scan(4'h0, 4'h1, 4'h2, 4'h4);
    idle(1);
    check("s2_strobe", 16'(strobes_seen - base), 16'd1);
    check("s2_digits", {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 16'h4210);

    // Skipped slot: seq_err, match count restarts from the next clean scan.
    base = strobes_seen;
    cyc(enc(4'h0), 5'b00001);
    cyc(enc(4'h1), 5'b00010);
    cyc(enc(4'h2), 5'b01000);
    idle(1);
    check("s3_seq_err", 16'(bus.seq_err), 16'd1);
    scan(4'h0, 4'h1, 4'h2, 4'h4);
    idle(1);
    check("s3_cnt_one", 16'(strobes_seen - base), 16'd0);
    scan(4'h0, 4'h1, 4'h2, 4'h4);
    idle(1);
    check("s3_cnt_two", 16'(strobes_seen - base), 16'd1);

    // Unknown pattern on slot 2 and a two-hot anode in the first scan.
    base = strobes_seen; sbase = seg_seen; abase = an_seen; qbase = seq_seen;
    cyc(enc(4'h0), 5'b00001);
    cyc(enc(4'h1), 5'b00010);
    cyc(enc(4'h3), 5'b00011);
    cyc(8'h7F, 5'b00100);
    cyc(enc(4'h3), 5'b01000);
    scan(4'h0, 4'h1, 4'hE, 4'h3);
    idle(1);
    check("s4_digit2_e", 16'(bus.digit_2), 16'h000E);
    check("s4_seg_errs", 16'(seg_seen - sbase), 16'd2);
    check("s4_anode_errs", 16'(an_seen - abase), 16'd1);
    check("s4_seq_errs", 16'(seq_seen - qbase), 16'd0);
    check("s4_strobe", 16'(strobes_seen - base), 16'd1);

    // Idle gaps and slot 1 held for three cycles, last value wins.
    base = strobes_seen;
    for (int k = 0; k < 2; k++) begin
      cyc(enc(4'h0), 5'b00001);
      idle(1);
      cyc(8'h5B, 5'b00010);
      cyc(8'h4F, 5'b00010);
      cyc(8'h06, 5'b00010);
      idle(2);
      cyc(enc(4'h2), 5'b00100);
      idle(1);
      cyc(enc(4'h3), 5'b01000);
    end
    idle(1);
    check("s5_strobe", 16'(strobes_seen - base), 16'd1);
    check("s5_digit1", 16'(bus.digit_1), 16'd1);
    check("s5_digits", {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 16'h3210);

    // Reset mid-frame discards history; the same frame needs two new scans.
    cyc(enc(4'h0), 5'b00001);
    cyc(enc(4'h1), 5'b00010);
    cyc(enc(4'h2), 5'b00100);
    do_reset();
    base = strobes_seen;
    scan(4'h0, 4'h1, 4'h2, 4'h3);
    idle(1);
    check("s6_first_scan", 16'(strobes_seen - base), 16'd0);
    scan(4'h0, 4'h1, 4'h2, 4'h3);
    idle(1);
    check("s6_second_scan", 16'(strobes_seen - base), 16'd1);
    check("s6_digits", {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 16'h3210);

    // Randomized scans, glitches and stray anodes against the model.
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        f = pool[$urandom_range(0, 2)];
        for (int s = 0; s < 4; s++) begin
          if ($urandom_range(0, 3) == 0) cyc(8'h00, 5'b00000);
          if ($urandom_range(0, 5) == 0) cyc(enc(f[s*4 +: 4]), 5'b00001 << s);
          cyc(enc(f[s*4 +: 4]), 5'b00001 << s);
        end
      end else if (r < 8) begin
        cyc(8'($urandom_range(0, 255)), 5'b00001 << $urandom_range(0, 3));
      end else begin
        cyc(8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)));
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
